// File: rtl/llc_proc_update_fifo.sv
// Show-ahead FIFO from LLC process stage to LLC update stage.
// Optional same-cycle bypass on empty: define LLC_PROC_UPDATE_FIFO_BYPASS_EN.
module llc_proc_update_fifo #(
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [8:0]               data_in,
  input  logic                     pop,
  output logic [8:0]               data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int AW = $clog2(DEPTH);

  // Packet bit layout:
  // [0] rst_to_resume   [1] flush_to_resume  [2] req_to_resume
  // [3] rst_to_get      [4] req_to_get       [5] rsp_to_get
  // [6] dma_req_to_get  [7] dma_read_to_resume [8] dma_write_to_resume
  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        ptr_empty;
  logic        hit;
  logic        byp;
  logic        do_push;
  logic        do_pop;

  assign ptr_empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &
                (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full = (count >= (AW+1)'(AFULL_THRESH));

`ifdef LLC_PROC_UPDATE_FIFO_BYPASS_EN
  assign hit = push & ptr_empty;
  assign byp = hit & pop;
`else
  assign hit = 1'b0;
  assign byp = 1'b0;
`endif

  assign empty = ptr_empty & ~hit;

  always_comb begin
    data_out = '0;
    if (hit)
      data_out = data_in;
    else if (!ptr_empty)
      data_out = mem[rd_ptr[AW-1:0]];
  end

  assign do_pop  = pop & ~ptr_empty;
  assign do_push = push & (~full | do_pop) & ~byp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full & ~pop)
        overflow_err <= 1'b1;
      if (pop & ptr_empty & ~byp)
        underflow_err <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_llc_proc_update_fifo.sv
// Directed table-driven bench for llc_proc_update_fifo (DEPTH=4).
module tb_llc_proc_update_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [8:0] data_in = '0;
  logic [8:0] data_out;
  logic       empty, full, almost_full;
  logic [2:0] count;
  logic       overflow_err, underflow_err;

  int checks = 0;
  int failures = 0;

  llc_proc_update_fifo #(.DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic [8:0] din;
    logic       e_empty;
    logic       e_full;
    logic       e_af;
    logic [2:0] e_count;
    logic [8:0] e_dout;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic p, logic q, logic [8:0] d,
                              logic em, logic fu, logic af,
                              logic [2:0] c, logic [8:0] o,
                              logic ov, logic un);
    vec_t v;
    v.push = p; v.pop = q; v.din = d;
    v.e_empty = em; v.e_full = fu; v.e_af = af;
    v.e_count = c; v.e_dout = o; v.e_ovf = ov; v.e_unf = un;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, logic em, logic fu, logic af,
                           logic [2:0] c, logic [8:0] o,
                           logic ov, logic un);
    chk("empty", idx, 16'(empty), 16'(em));
    chk("full", idx, 16'(full), 16'(fu));
    chk("almost_full", idx, 16'(almost_full), 16'(af));
    chk("count", idx, 16'(count), 16'(c));
    chk("data_out", idx, 16'(data_out), 16'(o));
    chk("overflow_err", idx, 16'(overflow_err), 16'(ov));
    chk("underflow_err", idx, 16'(underflow_err), 16'(un));
  endtask

  task automatic step(logic p, logic q, logic [8:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = '0;
    #1;
  endtask

  initial begin
    // in-order fill: req_to_get, rsp_to_get, dma_req_to_get, rst_to_resume
    vecs.push_back(mk(1,0,9'h010, 0,0,0,3'd1,9'h010,0,0));
    vecs.push_back(mk(1,0,9'h020, 0,0,0,3'd2,9'h010,0,0));
    vecs.push_back(mk(1,0,9'h040, 0,0,1,3'd3,9'h010,0,0));
    vecs.push_back(mk(1,0,9'h001, 0,1,1,3'd4,9'h010,0,0));
    vecs.push_back(mk(0,1,9'h000, 0,0,1,3'd3,9'h020,0,0));
    vecs.push_back(mk(0,1,9'h000, 0,0,0,3'd2,9'h040,0,0));
    vecs.push_back(mk(0,1,9'h000, 0,0,0,3'd1,9'h001,0,0));
    vecs.push_back(mk(0,1,9'h000, 1,0,0,3'd0,9'h000,0,0));
    // refill across the pointer wrap
    vecs.push_back(mk(1,0,9'h101, 0,0,0,3'd1,9'h101,0,0));
    vecs.push_back(mk(1,0,9'h102, 0,0,0,3'd2,9'h101,0,0));
    vecs.push_back(mk(1,0,9'h103, 0,0,1,3'd3,9'h101,0,0));
    vecs.push_back(mk(1,0,9'h104, 0,1,1,3'd4,9'h101,0,0));
    // push+pop while full
    vecs.push_back(mk(1,1,9'h0a1, 0,1,1,3'd4,9'h102,0,0));
    vecs.push_back(mk(1,1,9'h0a2, 0,1,1,3'd4,9'h103,0,0));
    vecs.push_back(mk(1,1,9'h0a3, 0,1,1,3'd4,9'h104,0,0));
    vecs.push_back(mk(1,1,9'h0a4, 0,1,1,3'd4,9'h0a1,0,0));
    vecs.push_back(mk(1,1,9'h0a5, 0,1,1,3'd4,9'h0a2,0,0));
    vecs.push_back(mk(1,1,9'h0a6, 0,1,1,3'd4,9'h0a3,0,0));
    // overflow: dropped packet must never appear
    vecs.push_back(mk(1,0,9'h1ff, 0,1,1,3'd4,9'h0a3,1,0));
    vecs.push_back(mk(0,1,9'h000, 0,0,1,3'd3,9'h0a4,1,0));
    vecs.push_back(mk(0,1,9'h000, 0,0,0,3'd2,9'h0a5,1,0));
    vecs.push_back(mk(0,1,9'h000, 0,0,0,3'd1,9'h0a6,1,0));
    vecs.push_back(mk(0,1,9'h000, 1,0,0,3'd0,9'h000,1,0));
`ifdef LLC_PROC_UPDATE_FIFO_BYPASS_EN
    vecs.push_back(mk(1,1,9'h002, 1,0,0,3'd0,9'h000,1,0));
    vecs.push_back(mk(1,0,9'h004, 0,0,0,3'd1,9'h004,1,0));
`else
    vecs.push_back(mk(1,1,9'h002, 0,0,0,3'd1,9'h002,1,1));
    vecs.push_back(mk(1,0,9'h004, 0,0,0,3'd2,9'h002,1,1));
`endif

    #12;
    check_all(-1, 1, 0, 0, 3'd0, 9'h000, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all(-2, 1, 0, 0, 3'd0, 9'h000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din);
      check_all(i, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_af,
                vecs[i].e_count, vecs[i].e_dout,
                vecs[i].e_ovf, vecs[i].e_unf);
    end

    // one more push, then async reset well before the next edge
    step(1, 0, 9'h008);
`ifdef LLC_PROC_UPDATE_FIFO_BYPASS_EN
    check_all(100, 0, 0, 0, 3'd2, 9'h004, 1, 0);
`else
    check_all(100, 0, 0, 1, 3'd3, 9'h002, 1, 1);
`endif
    rst = 1'b0;
    #1;
    check_all(101, 1, 0, 0, 3'd0, 9'h000, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all(102, 1, 0, 0, 3'd0, 9'h000, 0, 0);
    step(1, 0, 9'h080);
    check_all(103, 0, 0, 0, 3'd1, 9'h080, 0, 0);
    step(0, 1, 9'h000);
    check_all(104, 1, 0, 0, 3'd0, 9'h000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
